// File: rtl/byte_pack_tx.sv
// byte_pack_tx: packs a byte stream little-endian into DATA_WIDTH words and
// queues them in a DEPTH-entry FIFO with per-word lane-valid masks.
// Optional feature: define BYTE_PACK_TX_PARITY_EN to add parity_o, the XOR of
// all enabled lanes of the head word, stored per FIFO entry.
module byte_pack_tx #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [7:0]                    byte_i,
  input  logic                          byte_valid_i,
  output logic                          byte_ready_o,
  input  logic                          flush_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [DATA_WIDTH/8-1:0]       be_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
`ifdef BYTE_PACK_TX_PARITY_EN
  output logic                          parity_o,
`endif
  output logic                          idle_o
);

  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [DATA_WIDTH-1:0] word_q, word_d, cur_word, push_word;
  logic [LANES-1:0]      be_q, be_d, cur_be, push_be;

  logic [DATA_WIDTH-1:0] mem_q   [DEPTH];
  logic [LANES-1:0]      be_mem_q[DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;

  logic full, accept, push, pop, last_lane, flush_go;

  assign full         = (count_q == CW'(DEPTH));
  assign byte_ready_o = !full && (state_q != FLUSH);
  assign accept       = byte_valid_i && byte_ready_o;
  assign valid_o      = (count_q != '0);
  assign pop          = valid_o && ready_i;
  assign count_o      = count_q;
  assign idle_o       = (state_q == IDLE) && (count_q == '0);
  assign data_o       = mem_q[rd_ptr_q];
  assign be_o         = be_mem_q[rd_ptr_q];

  // Partial word as it looks after merging this cycle's accepted byte.
  always_comb begin
    cur_word = word_q;
    cur_be   = be_q;
    if (accept) begin
      cur_word[{lane_q, 3'b000} +: 8] = byte_i;
      cur_be[lane_q]                  = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, partial-word update and FIFO push decision.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    word_d    = word_q;
    be_d      = be_q;
    push      = 1'b0;
    push_word = cur_word;
    push_be   = cur_be;
    last_lane = accept && (lane_q == LW'(LANES - 1));
    flush_go  = flush_i && ((state_q == FILL) || accept);
    case (state_q)
      FLUSH: begin
        // A deferred flush drains as soon as the FIFO has a free slot.
        if (!full) begin
          push      = 1'b1;
          push_word = word_q;
          push_be   = be_q;
          state_d   = IDLE;
          lane_d    = '0;
          word_d    = '0;
          be_d      = '0;
        end
      end
      default: begin
        if (last_lane || (flush_go && !full)) begin
          push    = 1'b1;
          state_d = IDLE;
          lane_d  = '0;
          word_d  = '0;
          be_d    = '0;
        end else if (flush_go) begin
          // Partial word pending with a full FIFO: park it until space frees.
          state_d = FLUSH;
        end else if (accept) begin
          state_d = FILL;
          lane_d  = lane_q + LW'(1);
          word_d  = cur_word;
          be_d    = cur_be;
        end
      end
    endcase
  end

  // Partial-word registers; cleared words keep unused lanes at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q <= '0;
      word_q <= '0;
      be_q   <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      be_q   <= be_d;
    end
  end

  // Output FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i]    <= '0;
        be_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q]    <= push_word;
        be_mem_q[wr_ptr_q] <= push_be;
        wr_ptr_q           <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

`ifdef BYTE_PACK_TX_PARITY_EN
  logic             par_mem_q[DEPTH];
  logic             push_par;
  logic [DATA_WIDTH-1:0] lane_mask;

  // Parity over the enabled lanes of the word being pushed.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (push_be[i]) lane_mask[i*8 +: 8] = 8'hFF;
    end
    push_par = ^(push_word & lane_mask);
  end

  // Per-entry parity storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) par_mem_q[i] <= 1'b0;
    end else if (push) begin
      par_mem_q[wr_ptr_q] <= push_par;
    end
  end

  assign parity_o = par_mem_q[rd_ptr_q];
`endif

endmodule

// File: doc/byte_pack_tx.md
BYTE_PACK_TX -- requirements
Module: byte_pack_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 16: output word width; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter DEPTH, default 4: output FIFO entries; SHALL be a power of two and at least 2.
REQ-003 clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 byte_i  input  8  byte to pack.
REQ-006 byte_valid_i  input  1  byte_i is valid.
REQ-007 byte_ready_o  output  1  block can accept byte_i this cycle.
REQ-008 flush_i  input  1  emit the pending partial word.
REQ-009 data_o  output  DATA_WIDTH  packed word at the FIFO head.
REQ-010 be_o  output  DATA_WIDTH/8  lane-valid mask of data_o.
REQ-011 valid_o  output  1  data_o and be_o are valid (stream master).
REQ-012 ready_i  input  1  downstream accepts data_o.
REQ-013 count_o  output  $clog2(DEPTH+1)  FIFO occupancy.
REQ-014 idle_o  output  1  no partial word is pending and the FIFO is empty.

Function
REQ-015 A byte SHALL be accepted when byte_valid_i && byte_ready_o, and SHALL be written to lane lane_q (bits lane_q*8 +: 8), with the first byte in lane 0 (little-endian).
REQ-016 lane_q SHALL increment on each accepted byte and wrap to 0 when the final lane (DATA_WIDTH/8-1) is filled.
REQ-017 On filling the final lane, the word SHALL be pushed to the FIFO in the same cycle with be_o all ones; valid_o SHALL rise the next cycle if the FIFO was empty (latency 1).
REQ-018 byte_ready_o SHALL equal (count_o < DEPTH) && (state != FLUSH), derived from registered state only; there is no full-FIFO bypass.
REQ-019 valid_o SHALL equal (count_o != 0). A pop SHALL occur on valid_o && ready_i.
REQ-020 data_o and be_o SHALL hold stable while valid_o && !ready_i.
REQ-021 A simultaneous push and pop SHALL leave count_o unchanged. FIFO pointers SHALL wrap modulo DEPTH.
REQ-022 The FSM SHALL have the states IDLE (lane_q==0), FILL (lane_q>0) and FLUSH.
REQ-023 IDLE->FILL SHALL occur on an accepted byte that does not complete a word. FILL->IDLE SHALL occur on a word completion or on a flush push.
REQ-024 flush_i in FILL with count_o<DEPTH SHALL push the partial word immediately, with be_o set to the filled lanes and unused lanes zero; lane_q SHALL then reset to 0.
REQ-025 flush_i in FILL with the FIFO full SHALL move the FSM to FLUSH; the partial word SHALL be pushed on the first cycle count_o<DEPTH, and the FSM SHALL then return to IDLE.
REQ-026 flush_i in IDLE, or flush_i while already in FLUSH, SHALL be a no-op.
REQ-027 A byte accepted in the same cycle as flush_i SHALL be included in the flushed word. If that byte completes the word, the push SHALL be a single full word.
REQ-028 idle_o SHALL equal (state==IDLE) && (count_o==0).

Reset
REQ-029 While rst_ni is low: state=IDLE, lane_q=0, FIFO empty, valid_o=0, data_o=0, be_o=0, count_o=0, idle_o=1, byte_ready_o=1.
REQ-030 Reset asserted mid-operation SHALL discard the partial word and all FIFO contents; no word SHALL be emitted after release until new bytes arrive.

Configuration
REQ-031 Macro BYTE_PACK_TX_PARITY_EN defined: an output port parity_o (1 bit) SHALL exist and equal the XOR of all data_o bits in lanes enabled by be_o; parity SHALL be stored per FIFO entry and reset to 0.
REQ-032 Macro BYTE_PACK_TX_PARITY_EN undefined: the parity_o port and its storage SHALL be absent, with all other behaviour identical.

Verification (DATA_WIDTH=16, DEPTH=4)
REQ-033 Bytes 0x11 then 0x22 with ready_i=1 -> one cycle later valid_o=1, data_o=0x2211, be_o=2'b11; count_o returns to 0 after the pop.
REQ-034 Byte 0xAB then flush_i -> data_o=0x00AB, be_o=2'b01, idle_o=1 after the pop.
REQ-035 ready_i=0, 8 bytes 0x01..0x08 -> count_o=4, byte_ready_o=0, data_o held at 0x0201; raising ready_i pops 0x0201, 0x0403, 0x0605, 0x0807 in order.
REQ-036 FIFO full, FILL holding 0xCC, flush_i pulse -> state FLUSH, byte_ready_o=0; after one pop, 0x00CC with be_o=2'b01 is pushed, FSM returns to IDLE.
REQ-037 rst_ni pulsed low with count_o=3 and lane_q=1 -> valid_o=0, count_o=0, idle_o=1; the next bytes 0x55, 0x66 yield 0x6655.
REQ-038 With BYTE_PACK_TX_PARITY_EN defined: word 0x0301 -> parity_o=1; partial 0x0007 with be_o=2'b01 -> parity_o=1.
